rst_seq_ctrl: RTL and testbench



---
 rtl/rst_seq_pkg.sv | 16 +
 rtl/rst_seq_ctrl.sv | 107 ++++++++++
 tb/tb_rst_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared state encoding and timer sizing for the subsystem reset sequencer
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // One timer serves both the hold phase and the per-subsystem ack wait,
    // so it must reach the larger of the two limits.
    function automatic int timer_w(input int hold_cycles, input int ack_timeout);
        return $clog2((hold_cycles > ack_timeout ? hold_cycles : ack_timeout) + 1);
    endfunction

endpackage

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: ordered subsystem reset sequencer with per-subsystem ready/timeout
//
// Ports:
//   clk_sys       in   system clock, the only clock
//   rst_n_sys     in   asynchronous active-low reset
//   rst_req       in   synchronous restart request (pulse or level, highest priority)
//   subsys_rdy    in   per-subsystem ready, already synchronous to clk_sys
//   subsys_rst_n  out  per-subsystem active-low resets, thermometer-coded from bit 0
//   seq_busy      out  high from sequence start until DONE
//   seq_done      out  high in DONE
//   timeout_vec   out  sticky per-subsystem ready-timeout flags
//   timeout_err   out  OR of timeout_vec
//   cur_idx       out  index being released or waited on
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_SUBSYS  = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int ACK_TIMEOUT = 1024,
    localparam int IW = (NUM_SUBSYS > 1) ? $clog2(NUM_SUBSYS) : 1
) (
    input  logic                  clk_sys,
    input  logic                  rst_n_sys,
    input  logic                  rst_req,
    input  logic [NUM_SUBSYS-1:0] subsys_rdy,
    output logic [NUM_SUBSYS-1:0] subsys_rst_n,
    output logic                  seq_busy,
    output logic                  seq_done,
    output logic [NUM_SUBSYS-1:0] timeout_vec,
    output logic                  timeout_err,
    output logic [IW-1:0]         cur_idx
);

    localparam int TW = timer_w(HOLD_CYCLES, ACK_TIMEOUT);

    seq_state_t    state;
    logic [TW-1:0] timer;
    logic          hold_end;
    logic          ack_end;
    logic          rdy_now;
    logic          last_idx;

    always_comb begin
        hold_end = (timer == TW'(HOLD_CYCLES - 1));
        ack_end  = (timer == TW'(ACK_TIMEOUT - 1));
        rdy_now  = subsys_rdy[cur_idx];
        last_idx = (cur_idx == IW'(NUM_SUBSYS - 1));
    end

    assign timeout_err = |timeout_vec;

    always_ff @(posedge clk_sys or negedge rst_n_sys) begin
        if (!rst_n_sys) begin
            state        <= HOLD;
            timer        <= '0;
            cur_idx      <= '0;
            subsys_rst_n <= '0;
            seq_busy     <= 1'b1;
            seq_done     <= 1'b0;
            timeout_vec  <= '0;
        end else if (rst_req) begin
            // Holding the timer at 0 makes the hold count start on the first cycle without rst_req.
            state        <= HOLD;
            timer        <= '0;
            cur_idx      <= '0;
            subsys_rst_n <= '0;
            seq_busy     <= 1'b1;
            seq_done     <= 1'b0;
            timeout_vec  <= '0;
        end else begin
            case (state)
                HOLD: begin
                    if (hold_end) begin
                        state        <= WAIT;
                        timer        <= '0;
                        cur_idx      <= '0;
                        subsys_rst_n <= NUM_SUBSYS'(1);
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT: begin
                    if (rdy_now || ack_end) begin
                        // Ready wins over a coincident timeout.
                        if (!rdy_now) timeout_vec[cur_idx] <= 1'b1;
                        if (last_idx) begin
                            state        <= DONE;
                            seq_busy     <= 1'b0;
                            seq_done     <= 1'b1;
                            subsys_rst_n <= '1;
                        end else begin
                            cur_idx      <= cur_idx + 1'b1;
                            timer        <= '0;
                            // Shifting in a 1 releases the next index and keeps the thermometer code.
                            subsys_rst_n <= (subsys_rst_n << 1) | NUM_SUBSYS'(1);
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: directed self-checking bench for rst_seq_ctrl with a release-event scoreboard
module tb_rst_seq_ctrl;

    localparam int N = 4;

    typedef struct {
        int b;
        int c;
    } ev_t;

    logic         clk_sys = 1'b0;
    logic         rst_n_sys = 1'b0;
    logic         rst_req = 1'b0;
    logic [N-1:0] subsys_rdy = '0;
    logic [N-1:0] subsys_rst_n;
    logic         seq_busy;
    logic         seq_done;
    logic [N-1:0] timeout_vec;
    logic         timeout_err;
    logic [1:0]   cur_idx;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [N-1:0] prev = '0;
    ev_t          exp_q[$];

    rst_seq_ctrl #(
        .NUM_SUBSYS (N),
        .HOLD_CYCLES(16),
        .ACK_TIMEOUT(8)
    ) dut (
        .clk_sys     (clk_sys),
        .rst_n_sys   (rst_n_sys),
        .rst_req     (rst_req),
        .subsys_rdy  (subsys_rdy),
        .subsys_rst_n(subsys_rst_n),
        .seq_busy    (seq_busy),
        .seq_done    (seq_done),
        .timeout_vec (timeout_vec),
        .timeout_err (timeout_err),
        .cur_idx     (cur_idx)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic logic thermo(input logic [N-1:0] v);
        logic [N:0] t;
        t = {1'b0, v} + 1'b1;
        return (t & {1'b0, v}) == '0;
    endfunction

    task automatic push(input int b, input int c);
        ev_t e;
        e.b = b;
        e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic push_seq(input int c0, input int c1, input int c2, input int c3);
        push(0, c0);
        push(1, c1);
        push(2, c2);
        push(3, c3);
    endtask

    task automatic to_cyc(input int t);
        while (cyc < t) @(negedge clk_sys);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    // Called at a negedge; k is the edge at which rst_req is sampled.
    task automatic restart(input logic [N-1:0] r, output int k);
        rst_req = 1'b1;
        subsys_rdy = r;
        k = cyc + 1;
        @(negedge clk_sys);
        rst_req = 1'b0;
        chk("req_rst_n", subsys_rst_n, 0);
        chk("req_tv", timeout_vec, 0);
        chk("req_busy", seq_busy, 1);
        chk("req_done", seq_done, 0);
    endtask

    // Release-event monitor: every rising subsys_rst_n bit is matched against the scoreboard.
    always @(posedge clk_sys) begin
        cyc++;
        #1;
        chk("thermometer", thermo(subsys_rst_n), 1);
        for (int b = 0; b < N; b++) begin
            if (subsys_rst_n[b] && !prev[b]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL rel_unexpected: bit %0d rose at cycle %0d, none expected", b, cyc);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("rel_bit", b, e.b);
                    chk("rel_cycle", cyc, e.c);
                end
            end
        end
        prev = subsys_rst_n;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int r;
        int k;
        int l;
        // Power-up reset state
        repeat (3) @(negedge clk_sys);
        chk("rst_rst_n", subsys_rst_n, 0);
        chk("rst_busy", seq_busy, 1);
        chk("rst_done", seq_done, 0);
        chk("rst_tv", timeout_vec, 0);
        chk("rst_err", timeout_err, 0);
        chk("rst_idx", cur_idx, 0);
        // Power-up with all ready high: edge 1 is the first edge with reset released
        subsys_rdy = 4'hF;
        rst_n_sys = 1'b1;
        t0 = cyc;
        push_seq(t0 + 16, t0 + 17, t0 + 18, t0 + 19);
        to_cyc(t0 + 15);
        chk("pu_hold", subsys_rst_n, 0);
        to_cyc(t0 + 19);
        chk("pu_all_rel", subsys_rst_n, 4'hF);
        chk("pu_not_done", seq_done, 0);
        to_cyc(t0 + 20);
        chk("pu_done", seq_done, 1);
        chk("pu_busy", seq_busy, 0);
        chk("pu_tv", timeout_vec, 0);
        chk("pu_idx", cur_idx, 3);
        drain(5);
        // rdy[1] low: timeout on index 1
        restart(4'b1101, r);
        push_seq(r + 16, r + 17, r + 25, r + 26);
        to_cyc(r + 24);
        chk("to_pre_tv", timeout_vec, 0);
        chk("to_pre_idx", cur_idx, 1);
        to_cyc(r + 25);
        chk("to_tv", timeout_vec, 4'b0010);
        chk("to_err", timeout_err, 1);
        to_cyc(r + 27);
        chk("to_done", seq_done, 1);
        chk("to_done_tv", timeout_vec, 4'b0010);
        drain(5);
        // rst_req pulse while in WAIT(2), with a timeout flag already set
        restart(4'b1001, r);
        push(0, r + 16);
        push(1, r + 17);
        push(2, r + 25);
        to_cyc(r + 28);
        chk("w2_idx", cur_idx, 2);
        chk("w2_rst_n", subsys_rst_n, 4'b0111);
        chk("w2_tv", timeout_vec, 4'b0010);
        restart(4'hF, k);
        push_seq(k + 16, k + 17, k + 18, k + 19);
        to_cyc(k + 15);
        chk("w2_hold", subsys_rst_n, 0);
        to_cyc(k + 20);
        chk("w2_done", seq_done, 1);
        drain(5);
        // rst_req held for 50 cycles in DONE
        rst_req = 1'b1;
        repeat (50) begin
            @(negedge clk_sys);
            chk("held_rst_n", subsys_rst_n, 0);
            chk("held_busy", seq_busy, 1);
        end
        rst_req = 1'b0;
        l = cyc;
        push_seq(l + 16, l + 17, l + 18, l + 19);
        to_cyc(l + 15);
        chk("held_post_hold", subsys_rst_n, 0);
        chk("held_post_busy", seq_busy, 1);
        to_cyc(l + 20);
        chk("held_post_done", seq_done, 1);
        drain(5);
        // rdy[2] arrives on the edge where the timer reaches its limit
        restart(4'b1011, r);
        push_seq(r + 16, r + 17, r + 18, r + 26);
        to_cyc(r + 25);
        chk("edge_idx", cur_idx, 2);
        chk("edge_rst_n", subsys_rst_n, 4'b0111);
        subsys_rdy = 4'hF;
        to_cyc(r + 26);
        chk("edge_tv", timeout_vec, 0);
        chk("edge_rst_n3", subsys_rst_n, 4'hF);
        to_cyc(r + 27);
        chk("edge_done", seq_done, 1);
        chk("edge_err", timeout_err, 0);
        drain(5);
        // rst_n_sys asserted mid-WAIT(1), between clock edges
        restart(4'b1101, r);
        push(0, r + 16);
        push(1, r + 17);
        to_cyc(r + 20);
        chk("ar_idx", cur_idx, 1);
        #2 rst_n_sys = 1'b0;
        #1;
        chk("ar_rst_n", subsys_rst_n, 0);
        chk("ar_busy", seq_busy, 1);
        chk("ar_done", seq_done, 0);
        chk("ar_idx0", cur_idx, 0);
        chk("ar_tv", timeout_vec, 0);
        drain(1);
        @(negedge clk_sys);
        subsys_rdy = 4'hF;
        rst_n_sys = 1'b1;
        t0 = cyc;
        push_seq(t0 + 16, t0 + 17, t0 + 18, t0 + 19);
        to_cyc(t0 + 20);
        chk("ar_re_done", seq_done, 1);
        drain(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
